// File: rtl/uart_tx.sv
// UART transmitter: pulls one word per frame from an upstream FIFO and
// serialises it as start bit, DBIT data bits (LSB first) and a stop period.
// Timing is in oversample ticks; one tick is every DVSR clk, 16 ticks per bit.
module uart_tx #(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int DVSR      = 163,
    parameter int DVSR_BITS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // The tick counter has to reach both 15 (start/data bits) and SB_TICK-1.
    localparam int TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int TICK_W   = $clog2(TICK_MAX);
    localparam int BIT_W    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DVSR_BITS-1:0] DIV_LAST       = DVSR_BITS'(DVSR - 1);
    localparam logic [TICK_W-1:0]    BIT_LAST_TICK  = TICK_W'(15);
    localparam logic [TICK_W-1:0]    STOP_LAST_TICK = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST       = BIT_W'(DBIT - 1);

    logic [1:0]           state_reg,    state_next;
    logic [DVSR_BITS-1:0] div_reg,      div_next;
    logic [TICK_W-1:0]    tick_cnt_reg, tick_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
    logic [DBIT-1:0]      shift_reg,    shift_next;
    logic                 tx_reg,       tx_next;
    logic                 busy_reg,     busy_next;
    logic                 tick;

    // The divider only runs during a frame, so it wraps exactly every DVSR clk
    // measured from the acceptance edge.
    assign tick = (div_reg == DIV_LAST);

    // Pop is combinational so the head word is taken on the very edge it is
    // seen; it is masked during reset so nothing is lost while held there.
    assign fifo_rd = reset_n && (state_reg == IDLE) && !fifo_empty;

    assign tx      = tx_reg;
    assign tx_busy = busy_reg;

    // Next-state logic: FSM, counters, shift register and registered line level.
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        if (state_reg == IDLE) begin
            div_next = div_reg;
        end else begin
            div_next = tick ? '0 : div_reg + DVSR_BITS'(1);
        end

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_next    = fifo_data;
                    div_next      = '0;
                    tick_cnt_next = '0;
                    bit_cnt_next  = '0;
                    tx_next       = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_reg == BIT_LAST_TICK) begin
                        tick_cnt_next = '0;
                        bit_cnt_next  = '0;
                        tx_next       = shift_reg[0];
                        state_next    = DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_reg == BIT_LAST_TICK) begin
                        tick_cnt_next = '0;
                        shift_next    = shift_reg >> 1;
                        if (bit_cnt_reg == BIT_LAST) begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                            tx_next      = shift_next[0];
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_reg == STOP_LAST_TICK) begin
                        tick_cnt_next = '0;
                        state_next    = IDLE;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State registers; reset aborts any frame in flight immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            div_reg      <= '0;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
        end
    end

endmodule
